// File: rtl/fetch_npc_pkg.sv
// Shared encodings for the fetch / next-PC stage: NPCOp codes, fetch FSM states, nop.
package fetch_npc_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        VALID = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_npc_npc_calc.sv
// Combinational next-PC: selects pc+4 / pc+imm / jalr target and reports low-bit misalignment.
module npc_calc
    import fetch_npc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_op,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic [31:0] npc,
    output logic        misaligned
);

    logic [31:0] target;

    always_comb begin
        target = pc + 32'd4;
        case (npc_op)
            NPC_BRANCH, NPC_JUMP: target = pc + imm;
            NPC_JALR:             target = alu_out;
            default:              target = pc + 32'd4;
        endcase
        // Misalignment is judged on the raw target, so a jalr with alu_out[0]=1
        // counts as misaligned even though its bit 0 would be cleared.
        misaligned = |target[1:0];
        npc        = {target[31:2], 2'b00};
    end

endmodule

// File: rtl/fetch_npc.sv
// Fetch / next-PC stage: owns the PC, fetches from imem, holds instr until retire.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned next-PC redirects to TRAP_VEC.
module fetch_npc
    import fetch_npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        stall,
    input  logic [2:0]  NPCOp,
    input  logic [31:0] imm,
    input  logic [31:0] alu_out,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  npc;
    logic         npc_misaligned;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .npc_op     (NPCOp),
        .imm        (imm),
        .alu_out    (alu_out),
        .npc        (npc),
        .misaligned (npc_misaligned)
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    logic unused_misaligned;
    assign unused_misaligned = npc_misaligned;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        imem_req   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                // rvalid without gnt belongs to an abandoned request
                if (imem_gnt && imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (retire && !stall) begin
                    state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    pc_d       = npc_misaligned ? TRAP_VEC : npc;
                    misalign_d = npc_misaligned;
`else
                    pc_d       = npc;
`endif
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == VALID);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign misalign    = misalign_q;

endmodule
